fpu_issue_queue: RTL and testbench
==================================

Name: fpu_issue_queue

Overview:
Request buffer directly upstream of pipelined_fpu. It accepts FPU requests (op plus two 32-bit operands) from a producer over a valid/ready handshake and stores them in order. It presents the oldest request to the FPU as start/op/operand_a/operand_b, and pops the entry only when the FPU accepts it. The block absorbs FPU stall backpressure so the producer never has to hold operands itself.

Parameters:
DEPTH, 4, number of request entries; must be a power of 2 and at least 2
DATA_WIDTH, 32, operand width in bits

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous queue clear; priority over push
in_valid  input  1  producer presents a request
in_ready  output  1  queue can accept a request this cycle
in_op  input  3  FPU operation code
in_operand_a  input  DATA_WIDTH  first operand
in_operand_b  input  DATA_WIDTH  second operand
fpu_start  output  1  head request is valid; drives FPU start
fpu_op  output  3  head op
fpu_operand_a  output  DATA_WIDTH  head operand a
fpu_operand_b  output  DATA_WIDTH  head operand b
fpu_stall  input  1  FPU stall; when high the FPU does not take the head request
count  output  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Push = in_valid & in_ready. Pop = fpu_start & ~fpu_stall. Both take effect at the same clk edge.
- in_ready = (count < DEPTH) & ~reset. There is no pass-through when full: a full queue deasserts in_ready even if a pop happens the same cycle.
- fpu_start = (count != 0).
- The head is show-ahead: fpu_op and operands are combinational reads of the entry at rd_ptr. When empty they are forced to 0.
- Latency: a push in cycle N is visible as fpu_start=1 in cycle N+1 if the queue was empty. There is no combinational in_valid→fpu_start path.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged, both pointers advance.
- Simultaneous push and pop when count=0: not possible, because pop requires fpu_start.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is tracked separately; full/empty are derived from count only.
- While fpu_stall=1 with fpu_start=1, the head outputs hold stable, as pipelined_fpu requires.
- flush=1: at the next edge, count, wr_ptr and rd_ptr become 0. A same-cycle push is discarded and a same-cycle pop is ignored. in_ready still follows count during the flush cycle, but the push is dropped.
- Reset (sync, active-high): count=0, wr_ptr=rd_ptr=0.
  - Outputs after reset: fpu_start=0, fpu_op=0, operands=0, count=0.
  - in_ready=0 while reset is high and 1 in the first cycle after.
  - Reset mid-operation drops all queued requests. Storage array contents are not reset.
- Ordering is strict FIFO. No request is duplicated or lost except by flush or reset.
- There is no state machine beyond the pointers and counter. Legal count range is 0..DEPTH.
- Assertions:
  - count never exceeds DEPTH.
  - No push when full.
  - Head outputs stable while fpu_start & fpu_stall.

Decomposition:
- Package fpu_pkg holds:
  - typedef fpu_op_t (logic [2:0]) and the op-code constants.
  - typedef fpu_request_t, a packed struct {op, operand_a, operand_b}. Storage is an array of fpu_request_t.
- One natural sub-module: sync_fifo, a generic show-ahead FIFO with parameters WIDTH and DEPTH, push/pop, count and flush. fpu_issue_queue wraps it and adds the handshake mapping, masks the head outputs when empty, and gates in_ready with reset.

Test Plan:
- Reset, then in_valid=1 with op=3'd1, a=32'h3F800000, b=32'h40000000 for one cycle, fpu_stall=0 → next cycle fpu_start=1 with the same values, one cycle later fpu_start=0 and count=0.
- DEPTH=4, fpu_stall=1, push 5 requests with operand_a=1..5 → in_ready=0 after the 4th, count=4, 5th not accepted. Release stall → heads come out as 1,2,3,4 on consecutive cycles.
- count=2, push and pop in the same cycle → count stays 2. The next head is the second-oldest entry and the new entry lands at the tail.
- Push 7 and pop 7 with random stalls → output order matches input order. Pointers wrap at least once with no loss.
- count=3 with flush=1 and in_valid=1 in the same cycle → next cycle count=0, fpu_start=0 and all outputs 0. The flushed push does not appear.
- Assert reset while count=2 and fpu_stall=1 → in_ready=0 during reset, and next cycle fpu_start=0 and count=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU request types and op-code constants for the issue path in front of
// pipelined_fpu.
package fpu_pkg;

    localparam int unsigned FpuDataWidth = 32;

    typedef logic [2:0] fpu_op_t;

    localparam fpu_op_t FpuOpAdd  = 3'd0;
    localparam fpu_op_t FpuOpSub  = 3'd1;
    localparam fpu_op_t FpuOpMul  = 3'd2;
    localparam fpu_op_t FpuOpDiv  = 3'd3;
    localparam fpu_op_t FpuOpSqrt = 3'd4;
    localparam fpu_op_t FpuOpMin  = 3'd5;
    localparam fpu_op_t FpuOpMax  = 3'd6;
    localparam fpu_op_t FpuOpCmp  = 3'd7;

    typedef struct packed {
        fpu_op_t                  op;
        logic [FpuDataWidth-1:0]  operand_a;
        logic [FpuDataWidth-1:0]  operand_b;
    } fpu_request_t;

endpackage

// File: rtl/fpu_issue_queue_sync_fifo.sv
// Generic show-ahead FIFO: rdata is a combinational read of the head entry.
// Occupancy is held in a separate counter so pointers can wrap freely.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_wdata,
    output logic [WIDTH-1:0]             o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Guard internally too, so the FIFO stays consistent for any wrapper.
    assign w_do_push = i_push & (r_count != CntMax);
    assign w_do_pop  = i_pop & (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CntW'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CntW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fpu_issue_queue.sv
// In-order request buffer in front of pipelined_fpu; absorbs FPU stall backpressure
// and presents the oldest request show-ahead, zeroed when the queue is empty.
module fpu_issue_queue
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_op,
    input  logic [DATA_WIDTH-1:0]        in_operand_a,
    input  logic [DATA_WIDTH-1:0]        in_operand_b,
    output logic                         fpu_start,
    output logic [2:0]                   fpu_op,
    output logic [DATA_WIDTH-1:0]        fpu_operand_a,
    output logic [DATA_WIDTH-1:0]        fpu_operand_b,
    input  logic                         fpu_stall,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned EntryW = 3 + 2 * DATA_WIDTH;
    localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

    logic              w_push;
    logic              w_pop;
    logic              w_nonempty;
    logic [EntryW-1:0] w_wdata;
    logic [EntryW-1:0] w_rdata;
    logic [CntW-1:0]   w_count;
    fpu_op_t           w_head_op;

    assign w_wdata = {in_op, in_operand_a, in_operand_b};

    sync_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_flush (flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_count (w_count)
    );

    // No pass-through when full: a same-cycle pop does not reopen in_ready.
    assign w_nonempty = (w_count != '0);
    assign in_ready   = (w_count < CntMax) & ~reset;
    assign w_push     = in_valid & in_ready;
    assign w_pop      = w_nonempty & ~fpu_stall;

    assign w_head_op     = w_rdata[EntryW-1 -: 3];
    assign fpu_start     = w_nonempty;
    assign fpu_op        = w_nonempty ? w_head_op : '0;
    assign fpu_operand_a = w_nonempty ? w_rdata[2*DATA_WIDTH-1 -: DATA_WIDTH] : '0;
    assign fpu_operand_b = w_nonempty ? w_rdata[DATA_WIDTH-1:0] : '0;
    assign count         = w_count;

    a_count_in_range: assert property (@(posedge clk) disable iff (reset)
        w_count <= CntMax);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        w_push |-> (w_count < CntMax));

    a_head_stable_on_stall: assert property (@(posedge clk) disable iff (reset)
        (fpu_start && fpu_stall && !flush && !reset) |=>
            $stable({fpu_op, fpu_operand_a, fpu_operand_b}));

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Scoreboard bench for fpu_issue_queue: stimulus pushes expected requests, a negedge
// monitor pops and compares every request the FPU accepts.
module tb_fpu_issue_queue;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [31:0] in_operand_a = '0;
    logic [31:0] in_operand_b = '0;
    logic        fpu_start;
    logic [2:0]  fpu_op;
    logic [31:0] fpu_operand_a;
    logic [31:0] fpu_operand_b;
    logic        fpu_stall = 1'b0;
    logic [2:0]  count;

    fpu_request_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    fpu_issue_queue #(
        .DEPTH      (4),
        .DATA_WIDTH (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_operand_a  (in_operand_a),
        .in_operand_b  (in_operand_b),
        .fpu_start     (fpu_start),
        .fpu_op        (fpu_op),
        .fpu_operand_a (fpu_operand_a),
        .fpu_operand_b (fpu_operand_b),
        .fpu_stall     (fpu_stall),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Called just after a posedge; returns just after the edge that samples the push.
    task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic acc);
        fpu_request_t req;
        in_valid = 1'b1;
        in_op = op;
        in_operand_a = a;
        in_operand_b = b;
        @(negedge clk);
        acc = in_ready && !flush && !reset;
        req.op = op;
        req.operand_a = a;
        req.operand_b = b;
        if (acc) sb.push_back(req);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every request the FPU accepts must be the oldest one issued.
    always @(negedge clk) begin
        if (!reset && !flush && fpu_start && !fpu_stall) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got op=%0h a=%0h b=%0h, expected no request",
                         fpu_op, fpu_operand_a, fpu_operand_b);
            end else begin
                fpu_request_t exp;
                exp = sb.pop_front();
                if ({fpu_op, fpu_operand_a, fpu_operand_b} === exp) n_pass++;
                else $display("FAIL sb_order: got op=%0h a=%0h b=%0h, expected op=%0h a=%0h b=%0h",
                              fpu_op, fpu_operand_a, fpu_operand_b,
                              exp.op, exp.operand_a, exp.operand_b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic acc;

        // Reset
        @(posedge clk);
        @(negedge clk);
        check("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
        check("start_in_reset", {63'd0, fpu_start}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
        check("count_after_reset", {61'd0, count}, 64'd0);
        check("head_zero_after_reset", {fpu_op, fpu_operand_a, fpu_operand_b}, 64'd0);
        @(posedge clk);
        #1;

        // Single request, one-cycle latency
        push(3'd1, 32'h3F80_0000, 32'h4000_0000, acc);
        @(negedge clk);
        check("single_start", {63'd0, fpu_start}, 64'd1);
        check("single_count", {61'd0, count}, 64'd1);
        check("single_head", {fpu_op, fpu_operand_a, fpu_operand_b},
              {3'd1, 32'h3F80_0000, 32'h4000_0000});
        @(posedge clk);
        #1;
        @(negedge clk);
        check("single_drained_start", {63'd0, fpu_start}, 64'd0);
        check("single_drained_count", {61'd0, count}, 64'd0);
        @(posedge clk);
        #1;

        // Fill under stall, fifth push refused, then drain in order
        fpu_stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push(3'(i), 32'(i), ~32'(i), acc);
            check($sformatf("fill_accept_%0d", i), {63'd0, acc}, (i <= 4) ? 64'd1 : 64'd0);
        end
        @(negedge clk);
        check("full_count", {61'd0, count}, 64'd4);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 fpu_stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("drain_head_%0d", k), {32'd0, fpu_operand_a}, 64'(k));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("drain_count", {61'd0, count}, 64'd0);
        @(posedge clk);
        #1;

        // Simultaneous push and pop at count=2
        fpu_stall = 1'b1;
        push(3'd2, 32'd10, 32'd0, acc);
        push(3'd2, 32'd11, 32'd0, acc);
        fpu_stall = 1'b0;
        push(3'd3, 32'd12, 32'd0, acc);
        fpu_stall = 1'b1;
        @(negedge clk);
        check("pushpop_count", {61'd0, count}, 64'd2);
        check("pushpop_head", {32'd0, fpu_operand_a}, 64'd11);
        @(posedge clk);
        #1 fpu_stall = 1'b0;
        @(negedge clk);
        check("pushpop_next", {32'd0, fpu_operand_a}, 64'd11);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pushpop_tail", {32'd0, fpu_operand_a}, 64'd12);
        @(posedge clk);
        #1;

        // Seven requests with random stalls; pointers wrap
        fork
            begin
                for (int i = 0; i < 7; i++) begin
                    logic a2;
                    int tries;
                    a2 = 1'b0;
                    tries = 0;
                    while (!a2 && tries < 50) begin
                        push(3'(i), 32'(100 + i), 32'(200 + i), a2);
                        tries++;
                    end
                    if (!a2) check("random_push_timeout", 64'd0, 64'd1);
                end
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    fpu_stall = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                fpu_stall = 1'b0;
            end
        join
        for (int c = 0; c < 50 && count != 3'd0; c++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("random_drained_count", {61'd0, count}, 64'd0);
        check("random_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;

        // Flush with a same-cycle push
        fpu_stall = 1'b1;
        push(3'd4, 32'd20, 32'd1, acc);
        push(3'd4, 32'd21, 32'd1, acc);
        push(3'd4, 32'd22, 32'd1, acc);
        flush = 1'b1;
        push(3'd5, 32'd99, 32'd99, acc);
        flush = 1'b0;
        sb.delete();
        @(negedge clk);
        check("flush_count", {61'd0, count}, 64'd0);
        check("flush_start", {63'd0, fpu_start}, 64'd0);
        check("flush_head_zero", {fpu_op, fpu_operand_a, fpu_operand_b}, 64'd0);
        @(posedge clk);
        #1 fpu_stall = 1'b0;
        push(3'd6, 32'd30, 32'd31, acc);
        @(negedge clk);
        check("after_flush_head", {fpu_op, fpu_operand_a, fpu_operand_b}, {3'd6, 32'd30, 32'd31});
        @(posedge clk);
        #1;

        // Reset mid-operation
        fpu_stall = 1'b1;
        push(3'd7, 32'd40, 32'd0, acc);
        push(3'd7, 32'd41, 32'd0, acc);
        @(negedge clk);
        check("pre_reset_count", {61'd0, count}, 64'd2);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("mid_reset_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check("post_reset_start", {63'd0, fpu_start}, 64'd0);
        check("post_reset_count", {61'd0, count}, 64'd0);
        check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
